sim_exit_monitor: RTL and testbench



---
 rtl/sim_exit_monitor.sv | 130 +++++++++++++
 tb/tb_sim_exit_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_exit_monitor.sv
// Simulation exit monitor: decodes HTIF tohost exit writes, runs a retire watchdog,
// and reports a sticky success/failure after a drain period.
module sim_exit_monitor #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned CODE_W       = 32,
  parameter int unsigned HANG_LIMIT   = 1000000,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tohost_valid,
  output logic              tohost_ready,
  input  logic [DATA_W-1:0] tohost_data,
  input  logic              retire,
  output logic              success,
  output logic              failure,
  output logic [CODE_W-1:0] exit_code,
  output logic [1:0]        reason,
  output logic [CNT_W-1:0]  syscall_count
);

  localparam int unsigned HANG_W  = (HANG_LIMIT > 1) ? $clog2(HANG_LIMIT) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [HANG_W-1:0]  HANG_MAX   = HANG_W'((HANG_LIMIT == 0) ? 0 : HANG_LIMIT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_EXIT = 2'd1;
  localparam logic [1:0] R_HANG = 2'd2;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HANG_W-1:0]   hang_q, hang_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [1:0]          reason_q, reason_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                accept;
  logic                done_d;

  // Bits above the exit code field carry no meaning for the exit decode.
  if (DATA_W > CODE_W + 1) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^tohost_data[DATA_W-1:CODE_W+1];
  end

  assign accept = tohost_valid & tohost_ready;

  // Next-state: exit decode, syscall counting, watchdog and drain countdown.
  always_comb begin
    state_d  = state_q;
    hang_d   = hang_q;
    drain_d  = drain_q;
    code_d   = code_q;
    reason_d = reason_q;
    cnt_d    = syscall_count;
    case (state_q)
      S_RUN: begin
        if (accept && tohost_data[0]) begin
          code_d   = tohost_data[CODE_W:1];
          reason_d = (tohost_data[CODE_W:1] == '0) ? R_NONE : R_EXIT;
          drain_d  = DRAIN_INIT;
          state_d  = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else begin
          if (accept) begin
            cnt_d = (&syscall_count) ? syscall_count : syscall_count + CNT_W'(1);
          end
          if (retire) begin
            hang_d = '0;
          end else if (HANG_LIMIT != 0) begin
            if (hang_q == HANG_MAX) begin
              state_d  = S_DONE;
              reason_d = R_HANG;
              code_d   = '0;
            end else begin
              hang_d = hang_q + HANG_W'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q == DRAIN_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
      end
      default: state_d = S_RUN;
    endcase
  end

  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      hang_q        <= '0;
      drain_q       <= '0;
      code_q        <= '0;
      reason_q      <= R_NONE;
      tohost_ready  <= 1'b0;
      success       <= 1'b0;
      failure       <= 1'b0;
      exit_code     <= '0;
      reason        <= R_NONE;
      syscall_count <= '0;
    end else begin
      state_q       <= state_d;
      hang_q        <= hang_d;
      drain_q       <= drain_d;
      code_q        <= code_d;
      reason_q      <= reason_d;
      tohost_ready  <= 1'b1;
      // Report registers load on the same edge the FSM enters DONE.
      success       <= done_d && (reason_d == R_NONE);
      failure       <= done_d && (reason_d != R_NONE);
      exit_code     <= done_d ? code_d : '0;
      reason        <= done_d ? reason_d : R_NONE;
      syscall_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Directed bench for sim_exit_monitor: drain latency, exit decode, watchdog,
// saturation, asynchronous reset, plus a zero-drain/no-watchdog instance.
module tb_sim_exit_monitor;

  localparam int unsigned DRAIN = 16;

  logic        clock;
  logic        reset;
  logic        tohost_valid;
  logic        tohost_ready;
  logic [63:0] tohost_data;
  logic        retire;
  logic        success;
  logic        failure;
  logic [31:0] exit_code;
  logic [1:0]  reason;
  logic [15:0] syscall_count;

  logic        valid0;
  logic        ready0;
  logic        retire0;
  logic        success0;
  logic        failure0;
  logic [31:0] exit_code0;
  logic [1:0]  reason0;
  logic [15:0] syscall_count0;

  int vectors = 0;
  int miscompares = 0;

  sim_exit_monitor #(
    .DATA_W(64), .CODE_W(32), .HANG_LIMIT(100), .DRAIN_CYCLES(DRAIN), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset),
    .tohost_valid(tohost_valid), .tohost_ready(tohost_ready), .tohost_data(tohost_data),
    .retire(retire),
    .success(success), .failure(failure), .exit_code(exit_code), .reason(reason),
    .syscall_count(syscall_count)
  );

  sim_exit_monitor #(
    .DATA_W(64), .CODE_W(32), .HANG_LIMIT(0), .DRAIN_CYCLES(0), .CNT_W(16)
  ) dut0 (
    .clock(clock), .reset(reset),
    .tohost_valid(valid0), .tohost_ready(ready0), .tohost_data(tohost_data),
    .retire(retire0),
    .success(success0), .failure(failure0), .exit_code(exit_code0), .reason(reason0),
    .syscall_count(syscall_count0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_ready", tohost_ready, 0);
    check("rst_outs", {success, failure, reason, exit_code}, 0);
    step();
    reset = 1'b0;
    step();
    check("rst_release_ready", tohost_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    tohost_valid = 1'b0;
    tohost_data = '0;
    retire = 1'b0;
    valid0 = 1'b0;
    retire0 = 1'b0;
    #2;
    check("reset_ready", tohost_ready, 0);
    check("reset_outs", {success, failure, reason, exit_code}, 0);
    check("reset_count", syscall_count, 0);
    check("reset_dut0", {ready0, success0, failure0, reason0, exit_code0, syscall_count0}, 0);
    step();
    step();
    reset = 1'b0;
    retire = 1'b1;
    step();
    check("ready_up", tohost_ready, 1);
    check("ready_up_dut0", ready0, 1);

    // Zero-drain, watchdog-disabled instance: long stall is harmless, exit is immediate.
    repeat (300) step();
    check("d0_no_hang", {success0, failure0, reason0}, 0);
    tohost_data = 64'h5;
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    tohost_data = '0;
    check("d0_failure", {success0, failure0}, 2'b01);
    check("d0_code", exit_code0, 2);
    check("d0_reason", reason0, 1);

    // Test 1: clean exit, result appears exactly DRAIN edges after acceptance.
    tohost_data = 64'h1;
    tohost_valid = 1'b1;
    step();
    tohost_valid = 1'b0;
    tohost_data = '0;
    check("t1_at_accept", success, 0);
    for (int k = 1; k <= DRAIN; k++) begin
      step();
      check("t1_latency", success, (k == DRAIN) ? 1 : 0);
    end
    check("t1_fields", {failure, reason, exit_code}, 0);
    for (int k = 0; k < 100; k++) begin
      step();
      check("t1_hold", {success, failure}, 2'b10);
    end

    // Test 2: nonzero exit; a write during DRAIN is accepted and ignored.
    do_reset();
    tohost_data = 64'h55;
    tohost_valid = 1'b1;
    step();
    tohost_valid = 1'b0;
    for (int k = 1; k <= DRAIN; k++) begin
      if (k == 5) begin
        tohost_data = 64'h1;
        tohost_valid = 1'b1;
        check("t2_drain_ready", tohost_ready, 1);
        step();
        tohost_valid = 1'b0;
      end else begin
        step();
      end
      check("t2_latency", failure, (k == DRAIN) ? 1 : 0);
    end
    check("t2_success", success, 0);
    check("t2_code", exit_code, 32'h2A);
    check("t2_reason", reason, 1);
    repeat (5) step();
    check("t2_sticky", {failure, exit_code}, {1'b1, 32'h2A});

    // Test 3a: hang reported 100 edges after the last retire edge.
    do_reset();
    retire = 1'b1;
    step();
    retire = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      check("t3_hang_time", failure, (k == 100) ? 1 : 0);
    end
    check("t3_reason", reason, 2);
    check("t3_code", exit_code, 0);
    check("t3_success", success, 0);

    // Test 3b: retire on the threshold cycle clears the watchdog.
    do_reset();
    retire = 1'b1;
    step();
    retire = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      if (k == 100) retire = 1'b1;
      step();
      retire = 1'b0;
      check("t3_retire_wins", {success, failure}, 0);
    end

    // Test 4: exit write on the threshold cycle beats the hang.
    do_reset();
    retire = 1'b1;
    step();
    retire = 1'b0;
    repeat (99) step();
    tohost_data = 64'h1;
    tohost_valid = 1'b1;
    step();
    tohost_valid = 1'b0;
    tohost_data = '0;
    check("t4_no_hang", {failure, reason}, 0);
    for (int k = 1; k <= DRAIN; k++) begin
      step();
      check("t4_latency", {success, failure}, (k == DRAIN) ? 2'b10 : 2'b00);
    end
    check("t4_reason", reason, 0);

    // Test 5: syscall counter saturates; exit still works afterwards.
    do_reset();
    retire = 1'b1;
    tohost_data = 64'h2;
    tohost_valid = 1'b1;
    for (int i = 1; i <= 70000; i++) begin
      step();
      if (i == 10)    check("t5_count10", syscall_count, 10);
      if (i == 65534) check("t5_count_fffe", syscall_count, 16'hFFFE);
      if (i == 65535) check("t5_count_ffff", syscall_count, 16'hFFFF);
    end
    check("t5_saturated", syscall_count, 16'hFFFF);
    check("t5_no_result", {success, failure}, 0);
    tohost_data = 64'h1;
    step();
    tohost_valid = 1'b0;
    tohost_data = '0;
    repeat (DRAIN) step();
    check("t5_exit", {success, failure, reason}, 4'b1000);
    check("t5_count_held", syscall_count, 16'hFFFF);

    // Test 6: asynchronous reset mid-DRAIN, then a fresh exit.
    do_reset();
    retire = 1'b1;
    tohost_data = 64'h1;
    tohost_valid = 1'b1;
    step();
    tohost_valid = 1'b0;
    tohost_data = '0;
    repeat (5) step();
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_ready", tohost_ready, 0);
    check("t6_async_outs", {success, failure, reason, exit_code}, 0);
    check("t6_async_count", syscall_count, 0);
    step();
    reset = 1'b0;
    step();
    check("t6_ready", tohost_ready, 1);
    repeat (20) step();
    check("t6_no_stale", {success, failure}, 0);
    tohost_data = 64'h3;
    tohost_valid = 1'b1;
    step();
    tohost_valid = 1'b0;
    tohost_data = '0;
    repeat (DRAIN) step();
    check("t6_failure", {success, failure}, 2'b01);
    check("t6_code", exit_code, 1);
    check("t6_reason", reason, 1);

    // Asynchronous reset while DONE clears the report without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("t6_done_reset", {tohost_ready, success, failure, reason, exit_code}, 0);
    step();
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
